// File: rtl/tsc_multicycle_ctrl.sv
// rtl/tsc_multicycle_ctrl.sv - multi-cycle control FSM for the TSC CPU datapath
module tsc_multicycle_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_cpu,
  input  logic                 cpu_enable,
  input  logic                 i_ready,
  input  logic [WORD_SIZE-1:0] i_data,
  output logic                 i_req,
  output logic [WORD_SIZE-1:0] ir,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 alu_src_imm,
  output logic                 alu_latch,
  output logic                 wdata_lhi,
  output logic                 wreg_rd,
  output logic                 reg_write,
  output logic                 wwd_pulse,
  output logic [CNT_WIDTH-1:0] num_inst,
  output logic                 illegal_inst
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  localparam logic [3:0] OP_ADI   = 4'h4;
  localparam logic [3:0] OP_LHI   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_RTYPE = 4'hF;
  localparam logic [5:0] FN_ADD   = 6'h00;
  localparam logic [5:0] FN_WWD   = 6'h1C;

  state_t     state;
  state_t     next_state;
  logic [3:0] opcode;
  logic [5:0] func;
  logic       is_adi;
  logic       is_lhi;
  logic       is_jmp;
  logic       is_add;
  logic       is_wwd;
  logic       active;
  logic       set_illegal;

  assign opcode = ir[WORD_SIZE-1 -: 4];
  assign func   = ir[5:0];
  assign is_adi = (opcode == OP_ADI);
  assign is_lhi = (opcode == OP_LHI);
  assign is_jmp = (opcode == OP_JMP);
  assign is_add = (opcode == OP_RTYPE) && (func == FN_ADD);
  assign is_wwd = (opcode == OP_RTYPE) && (func == FN_WWD);

  // Strobes only fire when the core is running and not being reset.
  assign active = !reset_cpu && cpu_enable;

  // Next-state and per-state strobe decode; every output defaults to 0.
  always_comb begin
    next_state  = state;
    i_req       = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    alu_src_imm = 1'b0;
    alu_latch   = 1'b0;
    wdata_lhi   = 1'b0;
    wreg_rd     = 1'b0;
    reg_write   = 1'b0;
    wwd_pulse   = 1'b0;
    set_illegal = 1'b0;
    if (active) begin
      case (state)
        S_IDLE: next_state = S_FETCH;
        S_FETCH: begin
          i_req = 1'b1;
          if (i_ready) next_state = S_DECODE;
        end
        S_DECODE: begin
          if (is_jmp) begin
            pc_write   = 1'b1;
            pc_src     = 1'b1;
            next_state = S_FETCH;
          end else if (is_add || is_adi) begin
            next_state = S_EXEC;
          end else if (is_lhi || is_wwd) begin
            next_state = S_WB;
          end else begin
            // Unsupported encodings retire as a NOP and raise the sticky flag.
            pc_write    = 1'b1;
            set_illegal = 1'b1;
            next_state  = S_FETCH;
          end
        end
        S_EXEC: begin
          alu_latch   = 1'b1;
          alu_src_imm = is_adi;
          next_state  = S_WB;
        end
        S_WB: begin
          pc_write   = 1'b1;
          reg_write  = is_add || is_adi || is_lhi;
          wreg_rd    = is_add;
          wdata_lhi  = is_lhi;
          wwd_pulse  = is_wwd;
          next_state = S_FETCH;
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  // State, instruction register, retire counter and sticky flag; frozen while disabled.
  always_ff @(posedge clk) begin
    if (reset_cpu) begin
      state        <= S_IDLE;
      ir           <= '0;
      num_inst     <= '0;
      illegal_inst <= 1'b0;
    end else if (cpu_enable) begin
      state <= next_state;
      if (state == S_FETCH && i_ready) ir <= i_data;
      if (pc_write) num_inst <= num_inst + CNT_WIDTH'(1);
      if (set_illegal) illegal_inst <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tsc_multicycle_ctrl.sv
// tb/tb_tsc_multicycle_ctrl.sv - self-checking bench for tsc_multicycle_ctrl
module tb_tsc_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset_cpu;
  logic        cpu_enable;
  logic        i_ready;
  logic [15:0] i_data;

  logic        i_req, pc_write, pc_src, alu_src_imm, alu_latch;
  logic        wdata_lhi, wreg_rd, reg_write, wwd_pulse, illegal_inst;
  logic [15:0] ir, num_inst;

  logic        w_i_req, w_pc_write, w_pc_src, w_alu_src_imm, w_alu_latch;
  logic        w_wdata_lhi, w_wreg_rd, w_reg_write, w_wwd_pulse, w_illegal_inst;
  logic [15:0] w_ir;
  logic [3:0]  w_num_inst;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected-strobe bits: one entry per cycle of an instruction's post-fetch schedule.
  localparam logic [9:0] REQ = 10'h001;
  localparam logic [9:0] PW  = 10'h002;
  localparam logic [9:0] PCS = 10'h004;
  localparam logic [9:0] IMM = 10'h008;
  localparam logic [9:0] ALU = 10'h010;
  localparam logic [9:0] LHI = 10'h020;
  localparam logic [9:0] RD  = 10'h040;
  localparam logic [9:0] RW  = 10'h080;
  localparam logic [9:0] WWD = 10'h100;
  localparam logic [9:0] ILL = 10'h200;

  logic [9:0]  sched[$];
  bit          m_idle;
  logic [15:0] m_ir;
  logic [15:0] m_cnt;
  bit          m_ill;

  tsc_multicycle_ctrl dut (
    .clk(clk), .reset_cpu(reset_cpu), .cpu_enable(cpu_enable),
    .i_ready(i_ready), .i_data(i_data), .i_req(i_req), .ir(ir),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_imm(alu_src_imm),
    .alu_latch(alu_latch), .wdata_lhi(wdata_lhi), .wreg_rd(wreg_rd),
    .reg_write(reg_write), .wwd_pulse(wwd_pulse), .num_inst(num_inst),
    .illegal_inst(illegal_inst)
  );

  tsc_multicycle_ctrl #(.WORD_SIZE(16), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .reset_cpu(reset_cpu), .cpu_enable(cpu_enable),
    .i_ready(i_ready), .i_data(i_data), .i_req(w_i_req), .ir(w_ir),
    .pc_write(w_pc_write), .pc_src(w_pc_src), .alu_src_imm(w_alu_src_imm),
    .alu_latch(w_alu_latch), .wdata_lhi(w_wdata_lhi), .wreg_rd(w_wreg_rd),
    .reg_write(w_reg_write), .wwd_pulse(w_wwd_pulse), .num_inst(w_num_inst),
    .illegal_inst(w_illegal_inst)
  );

  initial forever #5 clk = ~clk;

  // Schedule of strobe sets for each cycle after the accepted fetch, by instruction class.
  task automatic load_sched(input logic [15:0] d);
    sched.delete();
    if (d[15:12] == 4'h9) begin
      sched.push_back(PW | PCS);
    end else if (d[15:12] == 4'h4) begin
      sched.push_back(10'h0); sched.push_back(ALU | IMM); sched.push_back(PW | RW);
    end else if (d[15:12] == 4'hF && d[5:0] == 6'h00) begin
      sched.push_back(10'h0); sched.push_back(ALU); sched.push_back(PW | RW | RD);
    end else if (d[15:12] == 4'h6) begin
      sched.push_back(10'h0); sched.push_back(PW | RW | LHI);
    end else if (d[15:12] == 4'hF && d[5:0] == 6'h1C) begin
      sched.push_back(10'h0); sched.push_back(PW | WWD);
    end else begin
      sched.push_back(PW | ILL);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit rdy, input logic [15:0] d);
    logic [9:0] exp_v;
    logic [8:0] obs_v;
    logic [8:0] obs_w;
    logic [9:0] ent;
    reset_cpu  = r;
    cpu_enable = e;
    i_ready    = rdy;
    i_data     = d;
    #4;
    if (r || !e || m_idle) exp_v = 10'h0;
    else if (sched.size() > 0) exp_v = sched[0];
    else exp_v = REQ;
    obs_v = {wwd_pulse, reg_write, wreg_rd, wdata_lhi, alu_latch,
             alu_src_imm, pc_src, pc_write, i_req};
    obs_w = {w_wwd_pulse, w_reg_write, w_wreg_rd, w_wdata_lhi, w_alu_latch,
             w_alu_src_imm, w_pc_src, w_pc_write, w_i_req};
    check("strobes", {23'h0, obs_v}, {23'h0, exp_v[8:0]});
    check("ir", {16'h0, ir}, {16'h0, m_ir});
    check("num_inst", {16'h0, num_inst}, {16'h0, m_cnt});
    check("illegal_inst", {31'h0, illegal_inst}, {31'h0, m_ill});
    check("strobes_w4", {23'h0, obs_w}, {23'h0, exp_v[8:0]});
    check("num_inst_w4", {28'h0, w_num_inst}, {28'h0, m_cnt[3:0]});
    @(posedge clk);
    if (r) begin
      m_idle = 1'b1;
      sched.delete();
      m_ir  = 16'h0;
      m_cnt = 16'h0;
      m_ill = 1'b0;
    end else if (e) begin
      if (m_idle) begin
        m_idle = 1'b0;
      end else if (sched.size() > 0) begin
        ent = sched.pop_front();
        if (ent[1]) m_cnt = m_cnt + 16'h1;
        if (ent[9]) m_ill = 1'b1;
      end else if (rdy) begin
        m_ir = d;
        load_sched(d);
      end
    end
    #1;
  endtask

  // Assumes the core is in FETCH: stall `delay` cycles, deliver the word, then drain.
  task automatic run_instr(input logic [15:0] d, input int delay);
    int guard;
    for (int i = 0; i < delay; i++) cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
    cyc(1'b0, 1'b1, 1'b1, d);
    guard = 0;
    while (sched.size() > 0 && guard < 10) begin
      cyc(1'b0, 1'b1, 1'b0, 16'($urandom));
      guard++;
    end
  endtask

  initial begin
    logic [15:0] rd;
    reset_cpu  = 1'b1;
    cpu_enable = 1'b1;
    i_ready    = 1'b0;
    i_data     = 16'h0;
    m_idle = 1'b1; m_ir = 16'h0; m_cnt = 16'h0; m_ill = 1'b0;
    @(posedge clk);
    #1;

    cyc(1'b1, 1'b1, 1'b1, 16'hFFFF);
    cyc(1'b0, 1'b1, 1'b0, 16'h0);
    run_instr(16'h430F, 0);
    run_instr(16'h9013, 0);
    run_instr(16'hF5C0, 5);
    run_instr(16'hF81C, 0);
    run_instr(16'h610F, 0);

    cyc(1'b0, 1'b1, 1'b1, 16'hF5C0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 16'h9013);
    run_instr(16'h9013, 0);

    cyc(1'b0, 1'b1, 1'b1, 16'h430F);
    cyc(1'b1, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0);

    run_instr(16'h2000, 0);
    run_instr(16'h430F, 2);

    cyc(1'b0, 1'b0, 1'b1, 16'h1234);
    cyc(1'b0, 1'b0, 1'b1, 16'h1234);
    run_instr(16'h610F, 1);

    for (int i = 0; i < 20; i++) run_instr(16'h9013, 0);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 6))
        0: rd = 16'h430F ^ {4'h0, 12'($urandom)};
        1: rd = 16'h610F;
        2: rd = 16'h9013;
        3: rd = 16'hF5C0;
        4: rd = 16'hF81C;
        default: rd = 16'($urandom);
      endcase
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 2) == 0), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
